// File: rtl/dshot_pkg.sv
// dshot_pkg: shared command codes, throttle constants, FSM state type and
// the persistent-command predicate for the DShot command sequencer.
package dshot_pkg;

    localparam logic [5:0] CMD_MOTOR_STOP       = 6'd0;
    localparam logic [5:0] CMD_SPIN_DIR_1       = 6'd7;
    localparam logic [5:0] CMD_SPIN_DIR_2       = 6'd8;
    localparam logic [5:0] CMD_3D_OFF           = 6'd9;
    localparam logic [5:0] CMD_3D_ON            = 6'd10;
    localparam logic [5:0] CMD_SETTINGS_REQUEST = 6'd11;
    localparam logic [5:0] CMD_SAVE_SETTINGS    = 6'd12;
    localparam logic [5:0] CMD_SPIN_NORMAL      = 6'd20;
    localparam logic [5:0] CMD_SPIN_REVERSED    = 6'd21;

    localparam logic [10:0] THROTTLE_OFFSET = 11'd48;
    localparam logic [10:0] THROTTLE_3D_MID = 11'd1048;

    typedef enum logic [1:0] {
        ST_DISARMED,
        ST_ARMING,
        ST_ARMED,
        ST_FAILSAFE
    } state_t;

    function automatic logic is_persistent(input logic [5:0] code);
        return code inside {CMD_SPIN_DIR_1, CMD_SPIN_DIR_2, CMD_3D_OFF, CMD_3D_ON,
                            CMD_SAVE_SETTINGS, CMD_SPIN_NORMAL, CMD_SPIN_REVERSED};
    endfunction

endpackage

// File: rtl/dshot_repeat_filter.sv
// dshot_repeat_filter: tracks the last accepted frame and the length of the
// current run of identical command codes; flags the first frame of each run.
import dshot_pkg::*;

module dshot_repeat_filter #(
    parameter int CMD_REPEAT = 6,
    localparam int RW = $clog2(CMD_REPEAT) + 1
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          accept,
    input  logic          is_cmd,
    input  logic [5:0]    code,
    output logic          pulse,
    output logic [RW-1:0] count
);

    logic          last_cmd;
    logic [5:0]    last_code;
    logic [RW-1:0] run;

    // count is the run length including the frame presented this cycle
    assign pulse = accept && is_cmd && !(last_cmd && last_code == code);
    assign count = !is_cmd ? '0 : pulse ? RW'(1) : (&run ? run : run + 1'b1);

    always_ff @(posedge clk) begin
        if (!rstN) begin
            last_cmd  <= 1'b0;
            last_code <= '0;
            run       <= '0;
        end else if (accept) begin
            last_cmd  <= is_cmd;
            last_code <= code;
            run       <= count;
        end
    end

endmodule

// File: rtl/dshot_command_sequencer.sv
// dshot_command_sequencer: qualifies decoded DShot frames, runs the arming/failsafe FSM
// and drives throttle plus persistent settings. Define DSHOT_3D_EN for 3D throttle mapping.
import dshot_pkg::*;

module dshot_command_sequencer #(
    parameter int ARM_FRAMES     = 10,
    parameter int CMD_REPEAT     = 6,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        frameValid,
    input  logic [10:0] setSpeed,
    input  logic [5:0]  specialCommand,
    input  logic        isSpecialCommand,
    input  logic        CRCValid,
    input  logic        validSpeed,
    output logic        armed,
    output logic        failsafe,
    output logic [10:0] throttle,
    output logic        throttleReverse,
    output logic        cmdValid,
    output logic [5:0]  cmdCode,
    output logic        spinReversed,
    output logic        mode3d
);

    localparam int AW = $clog2(ARM_FRAMES) + 1;
    localparam int RW = $clog2(CMD_REPEAT) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam state_t ARM_ENTRY = ARM_FRAMES <= 1 ? ST_ARMED : ST_ARMING;

    state_t        state;
    logic [AW-1:0] arm_cnt;
    logic [AW-1:0] arm_next;
    logic [TW-1:0] idle_cnt;
    logic [RW-1:0] run_len;
    logic          run_start;
    logic          accept;
    logic          is_stop;
    logic          expire;
    logic          cmd_fire;
    logic          thr_rev;
    logic [10:0]   thr_val;

    dshot_repeat_filter #(.CMD_REPEAT(CMD_REPEAT)) u_filter (
        .clk    (clk),
        .rstN   (rstN),
        .accept (accept),
        .is_cmd (isSpecialCommand),
        .code   (specialCommand),
        .pulse  (run_start),
        .count  (run_len)
    );

    assign accept   = frameValid && CRCValid && (isSpecialCommand || validSpeed);
    assign is_stop  = isSpecialCommand && specialCommand == CMD_MOTOR_STOP;
    assign expire   = state != ST_DISARMED && !accept && idle_cnt == TW'(TIMEOUT_CYCLES - 1);
    assign arm_next = &arm_cnt ? arm_cnt : arm_cnt + 1'b1;
    // persistent codes fire once when the run reaches CMD_REPEAT; others on a run's first frame
    assign cmd_fire = accept && isSpecialCommand &&
                      (is_persistent(specialCommand)
                          ? (CMD_REPEAT == 1 ? run_start : run_len == RW'(CMD_REPEAT))
                          : run_start && specialCommand != CMD_MOTOR_STOP);

`ifdef DSHOT_3D_EN
    assign thr_rev = mode3d ? setSpeed < THROTTLE_3D_MID : spinReversed;
    assign thr_val = setSpeed - (mode3d && setSpeed >= THROTTLE_3D_MID ? THROTTLE_3D_MID : THROTTLE_OFFSET);
`else
    assign thr_rev = spinReversed;
    assign thr_val = setSpeed - THROTTLE_OFFSET;
    assign mode3d  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state           <= ST_DISARMED;
            arm_cnt         <= '0;
            idle_cnt        <= '0;
            armed           <= 1'b0;
            failsafe        <= 1'b0;
            throttle        <= '0;
            throttleReverse <= 1'b0;
            cmdValid        <= 1'b0;
            cmdCode         <= '0;
            spinReversed    <= 1'b0;
`ifdef DSHOT_3D_EN
            mode3d          <= 1'b0;
`endif
        end else begin
            idle_cnt <= accept ? '0 : (&idle_cnt ? idle_cnt : idle_cnt + 1'b1);
            cmdValid <= cmd_fire;
            if (cmd_fire)
                cmdCode <= specialCommand;
            if (cmd_fire && (specialCommand == CMD_SPIN_DIR_1 || specialCommand == CMD_SPIN_NORMAL))
                spinReversed <= 1'b0;
            if (cmd_fire && (specialCommand == CMD_SPIN_DIR_2 || specialCommand == CMD_SPIN_REVERSED))
                spinReversed <= 1'b1;
`ifdef DSHOT_3D_EN
            if (cmd_fire && specialCommand == CMD_3D_OFF)
                mode3d <= 1'b0;
            if (cmd_fire && specialCommand == CMD_3D_ON)
                mode3d <= 1'b1;
`endif
            if (expire) begin
                state    <= ST_FAILSAFE;
                armed    <= 1'b0;
                failsafe <= 1'b1;
            end else if (accept) begin
                case (state)
                    ST_DISARMED, ST_FAILSAFE: begin
                        arm_cnt <= is_stop ? AW'(1) : '0;
                        if (is_stop) begin
                            state    <= ARM_ENTRY;
                            armed    <= ARM_ENTRY == ST_ARMED;
                            failsafe <= 1'b0;
                        end
                    end
                    ST_ARMING: begin
                        if (!is_stop) begin
                            state   <= ST_DISARMED;
                            arm_cnt <= '0;
                        end else begin
                            arm_cnt <= arm_next;
                            if (arm_next == AW'(ARM_FRAMES)) begin
                                state <= ST_ARMED;
                                armed <= 1'b1;
                            end
                        end
                    end
                    ST_ARMED: state <= ST_ARMED;
                    default: state <= ST_DISARMED;
                endcase
            end
            // throttle only follows frames accepted while already armed
            if (expire || state != ST_ARMED) begin
                throttle        <= '0;
                throttleReverse <= 1'b0;
            end else if (accept) begin
                throttle        <= isSpecialCommand ? '0 : thr_val;
                throttleReverse <= !isSpecialCommand && thr_rev;
            end
        end
    end

endmodule

// File: tb/tb_dshot_command_sequencer.sv
// tb_dshot_command_sequencer: directed self-checking bench for the command sequencer.
module tb_dshot_command_sequencer;

    localparam int T = 200;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        frameValid = 1'b0;
    logic [10:0] setSpeed = '0;
    logic [5:0]  specialCommand = '0;
    logic        isSpecialCommand = 1'b0;
    logic        CRCValid = 1'b0;
    logic        validSpeed = 1'b0;
    logic        armed;
    logic        failsafe;
    logic [10:0] throttle;
    logic        throttleReverse;
    logic        cmdValid;
    logic [5:0]  cmdCode;
    logic        spinReversed;
    logic        mode3d;

    int checks = 0;
    int errors = 0;

    dshot_command_sequencer #(.ARM_FRAMES(10), .CMD_REPEAT(6), .TIMEOUT_CYCLES(T)) dut (
        .clk              (clk),
        .rstN             (rstN),
        .frameValid       (frameValid),
        .setSpeed         (setSpeed),
        .specialCommand   (specialCommand),
        .isSpecialCommand (isSpecialCommand),
        .CRCValid         (CRCValid),
        .validSpeed       (validSpeed),
        .armed            (armed),
        .failsafe         (failsafe),
        .throttle         (throttle),
        .throttleReverse  (throttleReverse),
        .cmdValid         (cmdValid),
        .cmdCode          (cmdCode),
        .spinReversed     (spinReversed),
        .mode3d           (mode3d)
    );

    always #5 clk = ~clk;

    // presents one frame at a negedge; returns at the next negedge with frameValid low
    task automatic send(input logic [10:0] spd, input logic crc = 1'b1, input logic vs = 1'b1);
        setSpeed         = spd;
        specialCommand   = spd[5:0];
        isSpecialCommand = spd < 11'd48;
        validSpeed       = vs && spd >= 11'd48;
        CRCValid         = crc;
        frameValid       = 1'b1;
        @(negedge clk);
        frameValid       = 1'b0;
    endtask

    task automatic do_reset;
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_reset;
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        checks++;
        if ({armed, failsafe, throttle, throttleReverse, cmdValid, cmdCode, spinReversed, mode3d} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {armed, failsafe, throttle, throttleReverse, cmdValid, cmdCode, spinReversed, mode3d});
        end
        repeat (T + 5) @(negedge clk);
        checks++;
        if (failsafe !== 1'b0) begin
            errors++;
            $display("FAIL disarmed_no_timeout: failsafe=%b expected 0", failsafe);
        end
    endtask

    task automatic test_arm;
        for (int i = 1; i <= 10; i++) begin
            send(11'd0);
            checks++;
            if (armed !== (i == 10)) begin
                errors++;
                $display("FAIL arm_frame_%0d: armed=%b expected %b", i, armed, i == 10);
            end
        end
        do_reset;
        for (int i = 0; i < 5; i++) send(11'd0);
        send(11'd100);
        for (int i = 0; i < 5; i++) send(11'd0);
        checks++;
        if (armed !== 1'b0) begin
            errors++;
            $display("FAIL arm_broken: armed=%b expected 0", armed);
        end
        for (int i = 0; i < 5; i++) send(11'd0);
        checks++;
        if (armed !== 1'b1) begin
            errors++;
            $display("FAIL arm_restart: armed=%b expected 1", armed);
        end
    endtask

    task automatic test_throttle;
        send(11'd1048);
        checks++;
        if (throttle !== 11'd1000 || throttleReverse !== 1'b0) begin
            errors++;
            $display("FAIL throttle_1048: throttle=%0d rev=%b expected 1000 0", throttle, throttleReverse);
        end
        send(11'd2047, 1'b0);
        checks++;
        if (throttle !== 11'd1000) begin
            errors++;
            $display("FAIL bad_crc_ignored: throttle=%0d expected 1000", throttle);
        end
        send(11'd2047, 1'b1, 1'b0);
        checks++;
        if (throttle !== 11'd1000) begin
            errors++;
            $display("FAIL invalid_speed_ignored: throttle=%0d expected 1000", throttle);
        end
        send(11'd48);
        checks++;
        if (throttle !== 11'd0) begin
            errors++;
            $display("FAIL throttle_min: throttle=%0d expected 0", throttle);
        end
        send(11'd2047);
        checks++;
        if (throttle !== 11'd1999) begin
            errors++;
            $display("FAIL throttle_max: throttle=%0d expected 1999", throttle);
        end
        send(11'd0);
        checks++;
        if (throttle !== 11'd0 || armed !== 1'b1) begin
            errors++;
            $display("FAIL stop_in_armed: throttle=%0d armed=%b expected 0 1", throttle, armed);
        end
    endtask

    task automatic test_persistent;
        for (int i = 1; i <= 5; i++) begin
            send(11'd21);
            checks++;
            if (cmdValid !== 1'b0) begin
                errors++;
                $display("FAIL cmd21_pre_%0d: cmdValid=%b expected 0", i, cmdValid);
            end
        end
        send(11'd300);
        checks++;
        if (throttle !== 11'd252 || throttleReverse !== 1'b0) begin
            errors++;
            $display("FAIL throttle_300: throttle=%0d rev=%b expected 252 0", throttle, throttleReverse);
        end
        for (int i = 1; i <= 6; i++) begin
            send(11'd21);
            checks++;
            if (cmdValid !== (i == 6)) begin
                errors++;
                $display("FAIL cmd21_run_%0d: cmdValid=%b expected %b", i, cmdValid, i == 6);
            end
        end
        checks++;
        if (cmdCode !== 6'd21 || spinReversed !== 1'b1 || throttle !== 11'd0) begin
            errors++;
            $display("FAIL cmd21_effect: code=%0d spin=%b throttle=%0d expected 21 1 0",
                     cmdCode, spinReversed, throttle);
        end
        for (int i = 1; i <= 3; i++) begin
            send(11'd21);
            checks++;
            if (cmdValid !== 1'b0) begin
                errors++;
                $display("FAIL cmd21_extra_%0d: cmdValid=%b expected 0", i, cmdValid);
            end
        end
        send(11'd148);
        checks++;
        if (throttle !== 11'd100 || throttleReverse !== 1'b1) begin
            errors++;
            $display("FAIL throttle_reversed: throttle=%0d rev=%b expected 100 1", throttle, throttleReverse);
        end
        for (int i = 1; i <= 6; i++) begin
            send(11'd20);
            checks++;
            if (cmdValid !== (i == 6)) begin
                errors++;
                $display("FAIL cmd20_run_%0d: cmdValid=%b expected %b", i, cmdValid, i == 6);
            end
        end
        checks++;
        if (spinReversed !== 1'b0 || cmdCode !== 6'd20) begin
            errors++;
            $display("FAIL cmd20_effect: spin=%b code=%0d expected 0 20", spinReversed, cmdCode);
        end
    endtask

    task automatic test_immediate;
        for (int i = 1; i <= 4; i++) begin
            send(11'd3);
            checks++;
            if (cmdValid !== (i == 1)) begin
                errors++;
                $display("FAIL cmd3_%0d: cmdValid=%b expected %b", i, cmdValid, i == 1);
            end
        end
        checks++;
        if (cmdCode !== 6'd3) begin
            errors++;
            $display("FAIL cmd3_code: code=%0d expected 3", cmdCode);
        end
        for (int i = 1; i <= 2; i++) begin
            send(11'd0);
            checks++;
            if (cmdValid !== 1'b0 || cmdCode !== 6'd3) begin
                errors++;
                $display("FAIL cmd0_no_pulse_%0d: cmdValid=%b code=%0d expected 0 3", i, cmdValid, cmdCode);
            end
        end
    endtask

    task automatic test_back_to_back;
        send(11'd5);
        checks++;
        if (cmdValid !== 1'b1 || cmdCode !== 6'd5) begin
            errors++;
            $display("FAIL b2b_first: cmdValid=%b code=%0d expected 1 5", cmdValid, cmdCode);
        end
        send(11'd6);
        checks++;
        if (cmdValid !== 1'b1 || cmdCode !== 6'd6) begin
            errors++;
            $display("FAIL b2b_second: cmdValid=%b code=%0d expected 1 6", cmdValid, cmdCode);
        end
        @(negedge clk);
        checks++;
        if (cmdValid !== 1'b0 || cmdCode !== 6'd6) begin
            errors++;
            $display("FAIL b2b_idle: cmdValid=%b code=%0d expected 0 6", cmdValid, cmdCode);
        end
    endtask

    task automatic test_timeout;
        send(11'd548);
        repeat (T - 1) @(negedge clk);
        checks++;
        if (failsafe !== 1'b0 || throttle !== 11'd500) begin
            errors++;
            $display("FAIL timeout_early: failsafe=%b throttle=%0d expected 0 500", failsafe, throttle);
        end
        @(negedge clk);
        checks++;
        if (failsafe !== 1'b1 || throttle !== 11'd0 || armed !== 1'b0) begin
            errors++;
            $display("FAIL timeout_expiry: failsafe=%b throttle=%0d armed=%b expected 1 0 0",
                     failsafe, throttle, armed);
        end
        for (int i = 0; i < 10; i++) send(11'd0);
        checks++;
        if (armed !== 1'b1 || failsafe !== 1'b0) begin
            errors++;
            $display("FAIL rearm: armed=%b failsafe=%b expected 1 0", armed, failsafe);
        end
        repeat (T - 1) @(negedge clk);
        send(11'd548);
        checks++;
        if (failsafe !== 1'b0 || armed !== 1'b1 || throttle !== 11'd500) begin
            errors++;
            $display("FAIL expiry_frame_wins: failsafe=%b armed=%b throttle=%0d expected 0 1 500",
                     failsafe, armed, throttle);
        end
        repeat (T - 1) @(negedge clk);
        checks++;
        if (failsafe !== 1'b0) begin
            errors++;
            $display("FAIL timeout_restarted: failsafe=%b expected 0", failsafe);
        end
    endtask

    task automatic test_mode3d;
        do_reset;
        for (int i = 1; i <= 6; i++) begin
            send(11'd10);
            checks++;
            if (cmdValid !== (i == 6)) begin
                errors++;
                $display("FAIL cmd10_run_%0d: cmdValid=%b expected %b", i, cmdValid, i == 6);
            end
        end
        for (int i = 0; i < 10; i++) send(11'd0);
        send(11'd500);
`ifdef DSHOT_3D_EN
        checks++;
        if (mode3d !== 1'b1 || armed !== 1'b1 || throttle !== 11'd452 || throttleReverse !== 1'b1) begin
            errors++;
            $display("FAIL mode3d_500: mode3d=%b armed=%b throttle=%0d rev=%b expected 1 1 452 1",
                     mode3d, armed, throttle, throttleReverse);
        end
        send(11'd1548);
        checks++;
        if (throttle !== 11'd500 || throttleReverse !== 1'b0) begin
            errors++;
            $display("FAIL mode3d_1548: throttle=%0d rev=%b expected 500 0", throttle, throttleReverse);
        end
`else
        checks++;
        if (mode3d !== 1'b0 || armed !== 1'b1 || throttle !== 11'd452 || throttleReverse !== 1'b0) begin
            errors++;
            $display("FAIL linear_500: mode3d=%b armed=%b throttle=%0d rev=%b expected 0 1 452 0",
                     mode3d, armed, throttle, throttleReverse);
        end
`endif
        for (int i = 0; i < 3; i++) send(11'd21);
        do_reset;
        checks++;
        if ({armed, failsafe, throttle, throttleReverse, cmdValid, cmdCode, spinReversed, mode3d} !== 23'd0) begin
            errors++;
            $display("FAIL midseq_reset: got %h expected 0",
                     {armed, failsafe, throttle, throttleReverse, cmdValid, cmdCode, spinReversed, mode3d});
        end
        for (int i = 1; i <= 6; i++) begin
            send(11'd21);
            checks++;
            if (cmdValid !== (i == 6)) begin
                errors++;
                $display("FAIL post_reset_run_%0d: cmdValid=%b expected %b", i, cmdValid, i == 6);
            end
        end
    endtask

    initial begin
        test_reset;
        test_arm;
        test_throttle;
        test_persistent;
        test_immediate;
        test_back_to_back;
        test_timeout;
        test_mode3d;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
